// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by this slice: FETCH_MISALIGN_TRAP_EN.
package inst_fetch_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    localparam inst_t NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between fetch, instruction memory and decode.
// master = fetch stage, slave = memory/decode environment.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    // Handshakes: imem_req&imem_gnt issues a fetch; imem_rvalid carries one word per
    // cycle in request order; id_valid&id_ready transfers {id_pc,id_inst,id_exc}, and
    // id_* stay stable while id_valid is high and id_ready low.
    logic       imem_req;
    inst_addr_t imem_addr;
    logic       imem_gnt;
    logic       imem_rvalid;
    inst_t      imem_rdata;
    logic       redirect;
    inst_addr_t redirect_pc;
    logic       id_valid;
    logic       id_ready;
    inst_addr_t id_pc;
    inst_t      id_inst;
    logic       id_exc;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_inst, id_exc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_inst, id_exc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/inst_fetch_queue.sv
// In-order fetch queue: entries in [head,fill) are filled, [fill,tail) await memory.
// With FETCH_MISALIGN_TRAP_EN a flush may preload one filled exception entry.
module inst_fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  logic                    inject_i,
    input  inst_addr_t              inject_pc_i,
    output logic                    head_exc_o,
`endif
    input  logic                    alloc_i,
    input  inst_addr_t              alloc_pc_i,
    input  logic                    fill_i,
    input  inst_t                   fill_inst_i,
    input  logic                    pop_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [$clog2(DEPTH):0]  unfilled_o,
    output logic                    head_valid_o,
    output inst_addr_t              head_pc_o,
    output inst_t                   head_inst_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   head_q, head_d, fill_q, fill_d, tail_q, tail_d;
    logic [PTR_W-1:0] head_idx, fill_idx, tail_idx;
    inst_addr_t       pc_q   [DEPTH];
    inst_t            inst_q [DEPTH];

    assign head_idx = head_q[PTR_W-1:0];
    assign fill_idx = fill_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];

    always_comb begin
        head_d = head_q;
        fill_d = fill_q;
        tail_d = tail_q;
        if (flush_i) begin
            head_d = '0;
            fill_d = '0;
            tail_d = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (inject_i) begin
                fill_d = PTR_ONE;
                tail_d = PTR_ONE;
            end
`endif
        end else begin
            if (pop_i)   head_d = head_q + PTR_ONE;
            if (fill_i)  fill_d = fill_q + PTR_ONE;
            if (alloc_i) tail_d = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= NOP_INST;
            end
        end else if (flush_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (inject_i) begin
                pc_q[0]   <= inject_pc_i;
                inst_q[0] <= NOP_INST;
            end
`endif
        end else begin
            if (alloc_i) pc_q[tail_idx]   <= alloc_pc_i;
            if (fill_i)  inst_q[fill_idx] <= fill_inst_i;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [DEPTH-1:0] exc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_q <= '0;
        end else if (flush_i) begin
            exc_q <= {{(DEPTH-1){1'b0}}, inject_i};
        end else if (alloc_i) begin
            exc_q[tail_idx] <= 1'b0;
        end
    end

    assign head_exc_o = head_valid_o & exc_q[head_idx];
`endif

    assign count_o      = tail_q - head_q;
    assign unfilled_o   = tail_q - fill_q;
    assign head_valid_o = (fill_q != head_q);
    assign head_pc_o    = pc_q[head_idx];
    assign head_inst_o  = inst_q[head_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, request gating, stale-response dropping, fetch queue.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of aligning them.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000,
    parameter int         DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  fetch_io
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DW    = CNT_W + 1;

    inst_addr_t       pc_q, pc_d;
    logic [DW-1:0]    drop_cnt_q, drop_cnt_d;
    logic [DW-1:0]    outstanding;
    logic [CNT_W-1:0] count, unfilled;
    logic             alloc, fill, pop, head_valid, halt;

    // Every response still owed by memory is either a drop or an unfilled entry.
    assign outstanding = drop_cnt_q + {1'b0, unfilled};

    assign fetch_io.imem_req = !rst && !fetch_io.redirect && !halt
                               && (count < CNT_W'(DEPTH))
                               && (outstanding < DW'(DEPTH));
    assign fetch_io.imem_addr = pc_q;

    assign alloc = fetch_io.imem_req & fetch_io.imem_gnt;
    assign fill  = fetch_io.imem_rvalid & !fetch_io.redirect
                   & (drop_cnt_q == '0) & (unfilled != '0);
    assign pop   = head_valid & fetch_io.id_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halt_q, inject;

    assign inject = fetch_io.redirect & (fetch_io.redirect_pc[1:0] != 2'b00);
    assign halt   = halt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else if (fetch_io.redirect) begin
            halt_q <= inject;
        end
    end
`else
    assign halt            = 1'b0;
    assign fetch_io.id_exc = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (fetch_io.redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d = fetch_io.redirect_pc;
`else
            pc_d = fetch_io.redirect_pc & 32'hFFFF_FFFC;
`endif
        end else if (alloc) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // A response landing in the redirect cycle is itself one of the discarded ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (fetch_io.redirect) begin
            drop_cnt_d = outstanding;
            if (fetch_io.imem_rvalid && outstanding != '0) drop_cnt_d = outstanding - DW'(1);
        end else if (fetch_io.imem_rvalid && drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always @(posedge clk) begin
        if (!rst && fetch_io.imem_rvalid) assert (outstanding != '0);
    end

    inst_fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (fetch_io.redirect),
`ifdef FETCH_MISALIGN_TRAP_EN
        .inject_i     (inject),
        .inject_pc_i  (fetch_io.redirect_pc),
        .head_exc_o   (fetch_io.id_exc),
`endif
        .alloc_i      (alloc),
        .alloc_pc_i   (pc_q),
        .fill_i       (fill),
        .fill_inst_i  (fetch_io.imem_rdata),
        .pop_i        (pop),
        .count_o      (count),
        .unfilled_o   (unfilled),
        .head_valid_o (head_valid),
        .head_pc_o    (fetch_io.id_pc),
        .head_inst_o  (fetch_io.id_inst)
    );

    assign fetch_io.id_valid = head_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: memory model with in-order variable latency,
// and a reference model of the expected decode stream kept as per-epoch queues.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_io (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected decode stream since last redirect: {exc, pc}; the first n_filled have data.
    logic [32:0] exp_q[$];
    int          n_filled = 0;
    // Requests accepted by memory and not yet answered.
    logic [31:0] mq_addr[$];
    int          mq_epoch[$];
    int          mq_rdy[$];
    int          epoch = 0;
    logic [31:0] model_pc = 32'h0;
    bit          halted = 1'b0;
    int          n_gnt = 0;
    int          n_pop = 0;
    bit          rdr_hit = 1'b0;

    int gnt_pct, rdy_pct, rsp_pct, rdr_pct, lat_min, lat_max;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic set_knobs(input int g, input int r, input int s, input int lmin, input int lmax, input int d);
        gnt_pct = g; rdy_pct = r; rsp_pct = s; lat_min = lmin; lat_max = lmax; rdr_pct = d;
    endtask

    // rdr_mode: 0 none, 1 forced, 2 random, 3 only when pop and response coincide.
    task automatic cycle(input int rdr_mode, input logic [31:0] rpc);
        logic        rdr;
        logic        exp_req;
        logic [32:0] head;
        bus.imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        bus.id_ready    = ($urandom_range(0, 99) < rdy_pct);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (mq_addr.size() != 0 && mq_rdy[0] <= cyc && $urandom_range(0, 99) < rsp_pct) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mq_addr[0]);
        end
        rdr = (rdr_mode == 1) || (rdr_mode == 2 && $urandom_range(0, 99) < rdr_pct);
        bus.redirect    = 1'b0;
        bus.redirect_pc = rpc;
        #1;
        if (rdr_mode == 3 && bus.id_valid && bus.id_ready && bus.imem_rvalid) begin
            rdr = 1'b1;
            rdr_hit = 1'b1;
        end
        bus.redirect = rdr;
        #1;

        check("id_valid", bus.id_valid, n_filled > 0);
        if (n_filled > 0) begin
            head = exp_q[0];
            check("id_pc", bus.id_pc, head[31:0]);
            check("id_inst", bus.id_inst, head[32] ? NOP_INST : mem_word(head[31:0]));
            check("id_exc", bus.id_exc, head[32]);
        end
        exp_req = !rdr && !halted && exp_q.size() < DEPTH && mq_addr.size() < DEPTH;
        check("imem_req", bus.imem_req, exp_req);
        if (bus.imem_req) check("imem_addr", bus.imem_addr, model_pc);

        if (n_filled > 0 && bus.id_ready) begin
            void'(exp_q.pop_front());
            n_filled--;
            n_pop++;
        end
        if (bus.imem_req && bus.imem_gnt) begin
            n_gnt++;
            exp_q.push_back({1'b0, model_pc});
            mq_addr.push_back(bus.imem_addr);
            mq_epoch.push_back(epoch);
            mq_rdy.push_back(cyc + $urandom_range(lat_min, lat_max));
            model_pc = model_pc + 32'd4;
        end
        if (bus.imem_rvalid) begin
            if (mq_epoch[0] == epoch) n_filled++;
            void'(mq_addr.pop_front());
            void'(mq_epoch.pop_front());
            void'(mq_rdy.pop_front());
        end
        if (rdr) begin
            exp_q.delete();
            n_filled = 0;
            epoch++;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin
                exp_q.push_back({1'b1, rpc});
                n_filled = 1;
                halted = 1'b1;
            end else begin
                model_pc = rpc;
                halted = 1'b0;
            end
`else
            model_pc = {rpc[31:2], 2'b00};
`endif
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int rdr_mode, input logic [31:0] rpc);
        for (int i = 0; i < n; i++) cycle(rdr_mode, rpc);
    endtask

    initial begin
        int          g0;
        logic [31:0] rpc;

        rst = 1'b1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        set_knobs(100, 100, 100, 1, 1, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_id_valid", bus.id_valid, 1'b0);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst_id_inst", bus.id_inst, NOP_INST);
        check("rst_id_exc", bus.id_exc, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming from reset with single-cycle memory.
        run(20, 0, 32'h0);
        check("t1_progress", n_pop >= 4, 1'b1);

        // Decode stall: exactly DEPTH fetches go out, then requests stop.
        set_knobs(100, 0, 100, 1, 1, 0);
        cycle(1, 32'h0);
        g0 = n_gnt;
        run(5, 0, 32'h0);
        check("t2_gnt_count", n_gnt - g0, DEPTH);
        check("t2_req_off", bus.imem_req, 1'b0);
        set_knobs(100, 100, 100, 1, 1, 0);
        run(10, 0, 32'h0);

        // Redirect with slow responses in flight.
        set_knobs(100, 100, 100, 3, 3, 0);
        run(6, 0, 32'h0);
        cycle(1, 32'h0000_0100);
        run(15, 0, 32'h0);

        // Redirect coinciding with a response and a pop.
        set_knobs(100, 100, 100, 1, 1, 0);
        for (int i = 0; i < 40; i++) cycle(rdr_hit ? 0 : 3, 32'h0000_0040);
        check("t4_coincident", rdr_hit, 1'b1);
        run(10, 0, 32'h0);

        // PC wrap-around.
        cycle(1, 32'hFFFF_FFF8);
        run(12, 0, 32'h0);

        // Random traffic with occasional redirects.
        set_knobs(50, 60, 70, 1, 3, 3);
        for (int i = 0; i < 1500; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            cycle(2, rpc);
        end

        // Misaligned redirect, then resume.
        set_knobs(100, 0, 100, 1, 2, 0);
        cycle(1, 32'h0000_0102);
        run(5, 0, 32'h0);
        set_knobs(100, 100, 100, 1, 2, 0);
        run(5, 0, 32'h0);
        cycle(1, 32'h0000_0200);
        run(10, 0, 32'h0);

        // Drain everything outstanding.
        set_knobs(0, 100, 100, 1, 1, 0);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && mq_addr.size() == 0) break;
            cycle(0, 32'h0);
        end
        check("drain_exp", exp_q.size(), 0);
        check("drain_mem", mq_addr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
